// File: rtl/m_axi4_fsb_reader.sv
// Host-to-FSB reader: fetches 64B lines from a circular buffer in host memory
// over the AXI4 read channels, one line per read, and presents the flagged
// 80-bit packets of each line to an FSB client valid/yumi-style.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   en_i                    fetch enable (sampled only while idle)
//   cfg_base_addr_i         ring base byte address (low 6 bits ignored)
//   cfg_num_lines_i         ring size in lines, 0 = disabled
//   cfg_wr_ptr_i            host producer pointer, in lines
//   rd_ptr_o                consumer pointer, in lines
//   err_o                   sticky error: non-OKAY rresp seen
//   ar*_o / arready_i       AXI4 read-address channel
//   r*_i / rready_o         AXI4 read-data channel
//   fsb_v_o, fsb_data_o     FSB packet out
//   fsb_yumi_i              FSB consumer accept
module m_axi4_fsb_reader #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned FSB_WIDTH  = 80,
  parameter int unsigned PTR_WIDTH  = 16,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [63:0]           cfg_base_addr_i,
  input  logic [PTR_WIDTH-1:0]  cfg_num_lines_i,
  input  logic [PTR_WIDTH-1:0]  cfg_wr_ptr_i,
  output logic [PTR_WIDTH-1:0]  rd_ptr_o,
  output logic                  err_o,
  output logic [5:0]            arid_o,
  output logic [63:0]           araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [5:0]            rid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic                  fsb_v_o,
  output logic [FSB_WIDTH-1:0]  fsb_data_o,
  input  logic                  fsb_yumi_i
);

  localparam int unsigned NUM_SLOTS  = 4;
  localparam int unsigned SLOT_WIDTH = DATA_WIDTH / NUM_SLOTS;
  localparam int unsigned SEL_WIDTH  = $clog2(NUM_SLOTS);
  localparam int unsigned LINE_SHIFT = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_RWAIT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 state_q;
  logic [NUM_SLOTS-1:0]   mask_q;
  logic [FSB_WIDTH-1:0]   slot_q [NUM_SLOTS];

  logic [SEL_WIDTH-1:0]   sel;
  logic [NUM_SLOTS-1:0]   sel_oh;
  logic [NUM_SLOTS-1:0]   mask_rem;
  logic                   line_done;
  logic                   empty;
  logic [PTR_WIDTH-1:0]   ptr_inc;
  logic [63:0]            base_line;
  logic                   unused_bits;

  // Single-beat 64B reads with a fixed ID.
  assign arid_o   = 6'(AXI_ID);
  assign arlen_o  = 8'd0;
  assign arsize_o = 3'd6;

  assign base_line = {cfg_base_addr_i[63:LINE_SHIFT], LINE_SHIFT'(0)};
  assign empty     = (rd_ptr_o == cfg_wr_ptr_i) || (cfg_num_lines_i == '0);
  assign ptr_inc   = rd_ptr_o + PTR_WIDTH'(1);

  // Lowest pending slot is the one on offer.
  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        sel    = SEL_WIDTH'(k);
        sel_oh = NUM_SLOTS'(1) << k;
      end
    end
  end

  assign mask_rem  = mask_q & ~sel_oh;
  // Empty lines leave after one cycle; otherwise leave with the last accept.
  assign line_done = (mask_q == '0) || (fsb_yumi_i && (mask_rem == '0));

  // Decoded purely from registers, so no input-to-output path.
  assign fsb_v_o    = (state_q == S_DRAIN) && (mask_q != '0);
  assign fsb_data_o = slot_q[sel];

  // ID, last flag, slot padding and sub-line address bits carry no information.
  assign unused_bits = ^{rid_i, rlast_i, rdata_i, cfg_base_addr_i[LINE_SHIFT-1:0]};

  // Control FSM with registered AXI handshake outputs and line buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      araddr_o  <= '0;
      rd_ptr_o  <= '0;
      err_o     <= 1'b0;
      mask_q    <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_i && !empty) begin
            araddr_o  <= base_line + (64'(rd_ptr_o) << LINE_SHIFT);
            arvalid_o <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state_q   <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
              slot_q[k] <= rdata_i[k*SLOT_WIDTH +: FSB_WIDTH];
              mask_q[k] <= rdata_i[k*SLOT_WIDTH + SLOT_WIDTH - 1] && (rresp_i == 2'b00);
            end
            if (rresp_i != 2'b00) err_o <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (line_done) begin
            mask_q   <= '0;
            rd_ptr_o <= (ptr_inc == cfg_num_lines_i) ? '0 : ptr_inc;
            state_q  <= S_IDLE;
          end else if (fsb_yumi_i) begin
            mask_q <= mask_rem;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
